// File: rtl/print_line_buffer_if.sv
// Completed-line stream from print_line_buffer to its consumer.
// The producer drives line_valid/line_data; the consumer drives line_ready.
interface print_line_buffer_if #(
  parameter int unsigned HEAD_WIDTH = 384
) ();
  logic                  line_valid;
  logic [HEAD_WIDTH-1:0] line_data;
  logic                  line_ready;

  modport master (
    output line_valid,
    output line_data,
    input  line_ready
  );

  modport slave (
    input  line_valid,
    input  line_data,
    output line_ready
  );
endinterface

// File: rtl/print_line_buffer.sv
// Print line buffer: qualifies thermal-head burn pulses, assembles dot lines
// between stepper line boundaries and queues completed lines in a FIFO.
// Optional feature: define PRINT_LINE_BLANK_SKIP_EN to drop all-zero lines
// at the boundary and count them in blank_lines_skipped.
module print_line_buffer #(
  parameter int unsigned HEAD_WIDTH      = 384,
  parameter int unsigned STEPS_PER_LINE  = 2,
  parameter int unsigned MIN_BURN_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               head_active,
  input  logic [HEAD_WIDTH-1:0]              head_active_dots,
  input  logic                               line_advance_tick,
  input  logic                               line_reverse_tick,
  input  logic                               clear_overflow,
  print_line_buffer_if.master                line_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow,
  output logic [7:0]                         dropped_lines,
  output logic [15:0]                        blank_lines_skipped
);

  localparam int unsigned StepW = (STEPS_PER_LINE > 1) ? $clog2(STEPS_PER_LINE) : 1;
  localparam int unsigned RunW  = $clog2(MIN_BURN_CYCLES + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [StepW-1:0] StepLast = StepW'(STEPS_PER_LINE - 1);
  localparam logic [RunW-1:0]  RunMax   = RunW'(MIN_BURN_CYCLES);
  localparam logic [LvlW-1:0]  LvlFull  = LvlW'(FIFO_DEPTH);

  logic [RunW-1:0]       run_q, run_d, run_inc;
  logic [HEAD_WIDTH-1:0] pending_q, pending_d;
  logic [HEAD_WIDTH-1:0] burn_q, burn_d, burn_add;
  logic [StepW-1:0]      step_q, step_d;
  logic                  boundary;
  logic [PtrW-1:0]       wr_q, rd_q;
  logic [LvlW-1:0]       lvl_q, lvl_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drop_q, drop_d;
  logic                  valid, pop, push_req, push_ok, drop;
  logic [HEAD_WIDTH-1:0] mem [FIFO_DEPTH];

  assign run_inc = run_q + RunW'(1);

  // Burn qualification: hold dots in pending until the pulse is long enough.
  always_comb begin
    run_d     = '0;
    pending_d = '0;
    burn_add  = '0;
    if (head_active) begin
      if (run_q == RunMax) begin
        run_d    = RunMax;
        burn_add = head_active_dots;
      end else if (run_inc == RunMax) begin
        run_d    = RunMax;
        burn_add = pending_q | head_active_dots;
      end else begin
        run_d     = run_inc;
        pending_d = pending_q | head_active_dots;
      end
    end
  end

  // Step tracking; a forward wrap of step_q marks a line boundary.
  always_comb begin
    boundary = 1'b0;
    step_d   = step_q;
    if (line_advance_tick && !line_reverse_tick) begin
      if (step_q == StepLast) begin
        boundary = 1'b1;
        step_d   = '0;
      end else begin
        step_d = step_q + StepW'(1);
      end
    end else if (line_reverse_tick && !line_advance_tick && (step_q != '0)) begin
      step_d = step_q - StepW'(1);
    end
  end

  // The snapshot pushed at a boundary is burn_q; same-cycle burns start the new line.
  assign burn_d = (boundary ? '0 : burn_q) | burn_add;

`ifdef PRINT_LINE_BLANK_SKIP_EN
  logic        blank;
  logic [15:0] blank_q;
  assign blank    = boundary && (burn_q == '0);
  assign push_req = boundary && !blank;

  // Saturating blank-line counter, unaffected by clear_overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q <= '0;
    end else if (blank && (blank_q != 16'hFFFF)) begin
      blank_q <= blank_q + 16'd1;
    end
  end
  assign blank_lines_skipped = blank_q;
`else
  assign push_req            = boundary;
  assign blank_lines_skipped = '0;
`endif

  assign valid   = (lvl_q != '0);
  assign pop     = valid && line_if.line_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_req && ((lvl_q != LvlFull) || pop);
  assign drop    = push_req && (lvl_q == LvlFull) && !pop;

  // FIFO occupancy and sticky overflow; a drop wins over clear_overflow.
  always_comb begin
    lvl_d = lvl_q;
    if (push_ok && !pop) begin
      lvl_d = lvl_q + LvlW'(1);
    end else if (pop && !push_ok) begin
      lvl_d = lvl_q - LvlW'(1);
    end
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear_overflow) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = (drop_d == 8'hFF) ? 8'hFF : drop_d + 8'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q     <= '0;
      pending_q <= '0;
      burn_q    <= '0;
      step_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      lvl_q     <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      run_q     <= run_d;
      pending_q <= pending_d;
      burn_q    <= burn_d;
      step_q    <= step_d;
      lvl_q     <= lvl_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      if (push_ok) wr_q <= wr_q + PtrW'(1);
      if (pop)     rd_q <= rd_q + PtrW'(1);
    end
  end

  // Line storage; contents are don't-care until written, output is gated by valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= burn_q;
  end

  assign line_if.line_valid = valid;
  assign line_if.line_data  = valid ? mem[rd_q] : '0;
  assign fifo_level         = lvl_q;
  assign overflow           = ovf_q;
  assign dropped_lines      = drop_q;

endmodule

// File: tb/tb_print_line_buffer.sv
// Self-checking bench for print_line_buffer: a default instance (a) and a
// MIN_BURN_CYCLES=3 instance (b) share stimulus; directed tables/sequences
// plus randomized traffic checked against a queue-based line model.
`timescale 1ns/1ps
module tb_print_line_buffer;
  localparam int W     = 384;
  localparam int SPL   = 2;
  localparam int DEPTH = 4;
`ifdef PRINT_LINE_BLANK_SKIP_EN
  localparam bit BlankSkip = 1'b1;
`else
  localparam bit BlankSkip = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         head_active;
  logic [W-1:0] dots;
  logic         adv, rev, clr;
  logic [2:0]   lvl_a, lvl_b;
  logic         ov_a, ov_b;
  logic [7:0]   drp_a, drp_b;
  logic [15:0]  blk_a, blk_b;

  print_line_buffer_if #(.HEAD_WIDTH(W)) if_a ();
  print_line_buffer_if #(.HEAD_WIDTH(W)) if_b ();

  print_line_buffer #(.HEAD_WIDTH(W), .STEPS_PER_LINE(SPL), .MIN_BURN_CYCLES(1),
                      .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset(reset), .head_active(head_active), .head_active_dots(dots),
    .line_advance_tick(adv), .line_reverse_tick(rev), .clear_overflow(clr),
    .line_if(if_a), .fifo_level(lvl_a), .overflow(ov_a), .dropped_lines(drp_a),
    .blank_lines_skipped(blk_a));

  print_line_buffer #(.HEAD_WIDTH(W), .STEPS_PER_LINE(SPL), .MIN_BURN_CYCLES(3),
                      .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .reset(reset), .head_active(head_active), .head_active_dots(dots),
    .line_advance_tick(adv), .line_reverse_tick(rev), .clear_overflow(clr),
    .line_if(if_b), .fifo_level(lvl_b), .overflow(ov_b), .dropped_lines(drp_b),
    .blank_lines_skipped(blk_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    head_active = 1'b0; dots = '0; adv = 1'b0; rev = 1'b0; clr = 1'b0;
    if_a.line_ready = 1'b0; if_b.line_ready = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_burn [2];
  logic [W-1:0] m_pend [2];
  int           m_run [2], m_step [2], m_drop [2], m_blank [2];
  bit           m_ov [2];
  int           min_burn [2] = '{1, 3};
  logic [W-1:0] mq0 [$];
  logic [W-1:0] mq1 [$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_burn[k] = '0; m_pend[k] = '0; m_run[k] = 0; m_step[k] = 0;
      m_drop[k] = 0; m_blank[k] = 0; m_ov[k] = 1'b0;
    end
    mq0.delete();
    mq1.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // One clock of the line model for instance k, using the currently driven inputs.
  task automatic model_cycle(input int k, input bit ready);
    logic [W-1:0] snap, add;
    bit boundary, pop, push, blank;
    int sz;
    sz       = (k == 0) ? mq0.size() : mq1.size();
    pop      = ready && (sz > 0);
    snap     = m_burn[k];
    boundary = adv && !rev && (m_step[k] == SPL - 1);
    if (adv && !rev) m_step[k] = boundary ? 0 : m_step[k] + 1;
    else if (rev && !adv && m_step[k] > 0) m_step[k] = m_step[k] - 1;
    add = '0;
    if (head_active) begin
      m_run[k] = m_run[k] + 1;
      if (m_run[k] == min_burn[k]) add = m_pend[k] | dots;
      else if (m_run[k] > min_burn[k]) add = dots;
      else m_pend[k] = m_pend[k] | dots;
    end else begin
      m_run[k]  = 0;
      m_pend[k] = '0;
    end
    blank = boundary && BlankSkip && (snap == '0);
    push  = boundary && !blank;
    if (blank && m_blank[k] < 65535) m_blank[k] = m_blank[k] + 1;
    if (pop) begin
      if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
    end
    if (clr) begin
      m_ov[k]   = 1'b0;
      m_drop[k] = 0;
    end
    if (push) begin
      sz = (k == 0) ? mq0.size() : mq1.size();
      if (sz < DEPTH) begin
        if (k == 0) mq0.push_back(snap); else mq1.push_back(snap);
      end else begin
        m_ov[k] = 1'b1;
        if (m_drop[k] < 255) m_drop[k] = m_drop[k] + 1;
      end
    end
    m_burn[k] = (boundary ? '0 : m_burn[k]) | add;
  endtask

  task automatic model_check(input int k);
    logic [W-1:0] e_data;
    int sz;
    sz = (k == 0) ? mq0.size() : mq1.size();
    e_data = '0;
    if (sz > 0) e_data = (k == 0) ? mq0[0] : mq1[0];
    if (k == 0) begin
      chk("rand_a_valid", W'(if_a.line_valid), W'(sz > 0));
      chk("rand_a_data", if_a.line_data, e_data);
      chk("rand_a_level", W'(lvl_a), W'(sz));
      chk("rand_a_overflow", W'(ov_a), W'(m_ov[0]));
      chk("rand_a_dropped", W'(drp_a), W'(m_drop[0]));
      chk("rand_a_blank", W'(blk_a), W'(m_blank[0]));
    end else begin
      chk("rand_b_valid", W'(if_b.line_valid), W'(sz > 0));
      chk("rand_b_data", if_b.line_data, e_data);
      chk("rand_b_level", W'(lvl_b), W'(sz));
      chk("rand_b_overflow", W'(ov_b), W'(m_ov[1]));
      chk("rand_b_dropped", W'(drp_b), W'(m_drop[1]));
      chk("rand_b_blank", W'(blk_b), W'(m_blank[1]));
    end
  endtask

  // One burn cycle with dots d, then two advance ticks (one line boundary).
  task automatic burn_and_line(input logic [W-1:0] d);
    head_active = 1'b1; dots = d;
    tick();
    head_active = 1'b0; dots = '0; adv = 1'b1;
    tick();
    tick();
    adv = 1'b0;
  endtask

  typedef struct {
    bit         ha;
    logic [7:0] d;
    bit         adv;
    bit         rev;
    bit         rdy;
    bit         e_valid;
    int         e_lvl;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'h01};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00};
    tbl[4]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'h02};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1, 8'h02};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1, 8'h02};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'h02};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00};

    // Reset state of both instances.
    do_reset();
    chk("reset_a_valid", W'(if_a.line_valid), '0);
    chk("reset_a_data", if_a.line_data, '0);
    chk("reset_a_level", W'(lvl_a), '0);
    chk("reset_a_overflow", W'(ov_a), '0);
    chk("reset_a_dropped", W'(drp_a), '0);
    chk("reset_a_blank", W'(blk_a), '0);
    chk("reset_b_valid", W'(if_b.line_valid), '0);
    chk("reset_b_data", if_b.line_data, '0);
    chk("reset_b_level", W'(lvl_b), '0);
    chk("reset_b_overflow", W'(ov_b), '0);
    chk("reset_b_dropped", W'(drp_b), '0);
    chk("reset_b_blank", W'(blk_b), '0);

    // Basic line, step tracking with reverse and simultaneous ticks.
    for (int i = 0; i < 12; i++) begin
      head_active = tbl[i].ha; dots = W'(tbl[i].d);
      adv = tbl[i].adv; rev = tbl[i].rev; if_a.line_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), W'(if_a.line_valid), W'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_level", i), W'(lvl_a), W'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_data", i), if_a.line_data, W'(tbl[i].e_data));
    end
    idle_inputs();

    // MIN_BURN_CYCLES=3: short pulse discarded, 3-cycle pulse burns all its dots.
    do_reset();
    head_active = 1'b1; dots = W'(8'h02); tick(); tick();
    head_active = 1'b0; dots = '0; tick();
    head_active = 1'b1; dots = W'(8'h04); tick();
    dots = W'(8'h08); tick();
    dots = W'(8'h10); tick();
    head_active = 1'b0; dots = '0; adv = 1'b1; tick(); tick(); adv = 1'b0;
    chk("min3_level", W'(lvl_b), W'(1));
    chk("min3_data", if_b.line_data, W'(8'h1C));

    // Overflow: 6 lines into a depth-4 FIFO, then clear losing to a drop.
    do_reset();
    for (int i = 1; i <= 6; i++) burn_and_line(W'(i));
    chk("ovf_level", W'(lvl_a), W'(4));
    chk("ovf_flag", W'(ov_a), W'(1));
    chk("ovf_dropped", W'(drp_a), W'(2));
    head_active = 1'b1; dots = W'(8'h77); tick();
    head_active = 1'b0; dots = '0; adv = 1'b1; tick();
    clr = 1'b1; tick();
    adv = 1'b0; clr = 1'b0;
    chk("clr_vs_drop_flag", W'(ov_a), W'(1));
    chk("clr_vs_drop_count", W'(drp_a), W'(1));
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d_valid", i), W'(if_a.line_valid), W'(1));
      chk($sformatf("drain%0d_data", i), if_a.line_data, W'(i));
      if_a.line_ready = 1'b1; tick(); if_a.line_ready = 1'b0;
    end
    chk("drained_valid", W'(if_a.line_valid), '0);
    chk("drained_level", W'(lvl_a), '0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clear_flag", W'(ov_a), '0);
    chk("clear_count", W'(drp_a), '0);

    // Full FIFO with pop and boundary in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) burn_and_line(W'(11 + i));
    head_active = 1'b1; dots = W'(8'h55); tick();
    head_active = 1'b0; dots = '0; adv = 1'b1; tick();
    if_a.line_ready = 1'b1; tick();
    adv = 1'b0; if_a.line_ready = 1'b0;
    chk("fullpp_level", W'(lvl_a), W'(4));
    chk("fullpp_overflow", W'(ov_a), '0);
    chk("fullpp_head", if_a.line_data, W'(12));

    // Blank boundaries.
    do_reset();
    adv = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    adv = 1'b0;
    chk("blank_count", W'(blk_a), BlankSkip ? W'(3) : '0);
    chk("blank_level", W'(lvl_a), BlankSkip ? '0 : W'(3));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("blank%0d_data", i), if_a.line_data, '0);
      if_a.line_ready = 1'b1; tick(); if_a.line_ready = 1'b0;
      chk($sformatf("blank%0d_level", i), W'(lvl_a), BlankSkip ? '0 : W'(2 - i));
    end
    clr = 1'b1; tick(); clr = 1'b0;
    chk("blank_after_clear", W'(blk_a), BlankSkip ? W'(3) : '0);

    // Reset mid-operation: FIFO emptied, partial line and step discarded.
    do_reset();
    burn_and_line(W'(8'h07));
    head_active = 1'b1; dots = W'(8'h08); tick();
    head_active = 1'b0; dots = '0; adv = 1'b1; tick(); adv = 1'b0;
    reset = 1'b1;
    #2;
    chk("midrst_level", W'(lvl_a), '0);
    chk("midrst_valid", W'(if_a.line_valid), '0);
    tick();
    reset = 1'b0;
    adv = 1'b1; tick();
    chk("midrst_step_zeroed", W'(lvl_a), '0);
    tick(); adv = 1'b0;
    chk("midrst_line_level", W'(lvl_a), BlankSkip ? '0 : W'(1));
    chk("midrst_line_data", if_a.line_data, '0);

    // Randomized traffic against the line model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(9, 0) < 3) head_active = !head_active;
      dots = '0;
      if (head_active && $urandom_range(3, 0) != 0) begin
        dots[7:0] = 8'($urandom);
        for (int j = 0; j < 3; j++) dots[$urandom_range(W - 1, 0)] = 1'b1;
      end
      adv = ($urandom_range(99, 0) < 35);
      rev = ($urandom_range(99, 0) < 12);
      clr = ($urandom_range(99, 0) < 3);
      if_a.line_ready = ($urandom_range(99, 0) < 40);
      if_b.line_ready = ($urandom_range(99, 0) < 40);
      model_cycle(0, if_a.line_ready);
      model_cycle(1, if_b.line_ready);
      tick();
      model_check(0);
      model_check(1);
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
